// File: rtl/toy_pack.sv
// Shared rename-stage constants and helpers for the toy core.
package toy_pack;

    localparam int unsigned PHY_REG_NUM          = 64;
    localparam int unsigned PHY_REG_ID_WIDTH     = 6;
    localparam int unsigned ARCH_ENTRY_NUM       = 32;
    localparam int unsigned RENAME_ALLOC_CHANNEL = 4;
    localparam int unsigned FREE_CNT_WIDTH       = $clog2(PHY_REG_NUM + 1);

    typedef enum logic {
        StNormal,
        StRecover
    } freelist_state_e;

    // Both register classes start from the identity arch->phy mapping.
    function automatic logic [PHY_REG_NUM-1:0] reset_free_bm(int unsigned mode);
        logic [PHY_REG_NUM-1:0] bm;
        bm = '1;
        case (mode)
            0:       bm[ARCH_ENTRY_NUM-1:0] = '0;
            default: bm[ARCH_ENTRY_NUM-1:0] = '0;
        endcase
        return bm;
    endfunction

    function automatic logic [FREE_CNT_WIDTH-1:0] popcount(logic [PHY_REG_NUM-1:0] bm);
        logic [FREE_CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(PHY_REG_NUM); i++) begin
            cnt = cnt + FREE_CNT_WIDTH'(bm[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/toy_phy_freelist_pick.sv
// Finds the LANES lowest set bits of a bitmap; lane k gets the (k+1)-th lowest.
module toy_phy_freelist_pick #(
    parameter int unsigned NUM   = 64,
    parameter int unsigned ID_W  = 6,
    parameter int unsigned LANES = 4
) (
    input  logic [NUM-1:0]                   bm,
    output logic [LANES-1:0]                 valid,
    output logic [LANES-1:0][ID_W-1:0]       id,
    output logic [LANES-1:0][NUM-1:0]        onehot
);

    localparam int unsigned SEEN_W = $clog2(NUM + 1);

    logic [SEEN_W-1:0] seen;

    always_comb begin
        valid  = '0;
        id     = '0;
        onehot = '0;
        seen   = '0;
        for (int i = 0; i < int'(NUM); i++) begin
            if (bm[i]) begin
                for (int k = 0; k < int'(LANES); k++) begin
                    if (seen == SEEN_W'(k)) begin
                        valid[k]     = 1'b1;
                        id[k]        = ID_W'(i);
                        onehot[k][i] = 1'b1;
                    end
                end
                seen = seen + 1'b1;
            end
        end
    end

endmodule

// File: rtl/toy_phy_reg_freelist.sv
// Physical register free list: bitmap of free IDs, N-lane allocation, flush rebuild
// from the committed architectural mapping.
module toy_phy_reg_freelist
    import toy_pack::*;
#(
    parameter int unsigned MODE     = 0,
    parameter int unsigned ALLOC_CH = RENAME_ALLOC_CHANNEL
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [PHY_REG_NUM-1:0]                         v_phy_release,
    input  logic [PHY_REG_NUM-1:0]                         v_phy_release_comb,
    input  logic [ARCH_ENTRY_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_reg_backup_phy_id,
    input  logic                                           v_flush_en,
    output logic [ALLOC_CH-1:0]                            v_alloc_rdy,
    output logic [ALLOC_CH-1:0][PHY_REG_ID_WIDTH-1:0]      v_alloc_id,
    input  logic [ALLOC_CH-1:0]                            v_alloc_en,
    output logic [FREE_CNT_WIDTH-1:0]                      v_free_cnt,
    output logic                                           err_double_free,
    output logic                                           err_bad_alloc
);

    localparam logic [PHY_REG_NUM-1:0] RESET_BM = reset_free_bm(MODE);

    freelist_state_e                         state_q, state_d;
    logic [PHY_REG_NUM-1:0]                  free_bm_q, free_bm_d;
    logic [FREE_CNT_WIDTH-1:0]               free_cnt_q, free_cnt_d;
    logic                                    double_free_q, double_free_d;
    logic                                    bad_alloc_q, bad_alloc_d;

    logic [ALLOC_CH-1:0]                     pick_valid;
    logic [ALLOC_CH-1:0][PHY_REG_ID_WIDTH-1:0] pick_id;
    logic [ALLOC_CH-1:0][PHY_REG_NUM-1:0]    pick_onehot;

    logic [PHY_REG_NUM-1:0]                  alloc_mask;
    logic [PHY_REG_NUM-1:0]                  release_mask;
    logic [PHY_REG_NUM-1:0]                  arch_mask;

    toy_phy_freelist_pick #(
        .NUM   (PHY_REG_NUM),
        .ID_W  (PHY_REG_ID_WIDTH),
        .LANES (ALLOC_CH)
    ) u_pick (
        .bm     (free_bm_q),
        .valid  (pick_valid),
        .id     (pick_id),
        .onehot (pick_onehot)
    );

    always_comb begin
        v_alloc_rdy = '0;
        v_alloc_id  = '0;
        alloc_mask  = '0;
        for (int k = 0; k < int'(ALLOC_CH); k++) begin
            v_alloc_rdy[k] = (free_cnt_q > FREE_CNT_WIDTH'(k)) && pick_valid[k] &&
                             (state_q == StNormal) && !v_flush_en;
            if (v_alloc_rdy[k]) begin
                v_alloc_id[k] = pick_id[k];
                if (v_alloc_en[k]) begin
                    alloc_mask = alloc_mask | pick_onehot[k];
                end
            end
        end
    end

    assign release_mask = v_phy_release | v_phy_release_comb;

    always_comb begin
        arch_mask = '0;
        for (int j = 0; j < int'(ARCH_ENTRY_NUM); j++) begin
            arch_mask[v_reg_backup_phy_id[j]] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        free_bm_d     = free_bm_q;
        double_free_d = double_free_q;
        bad_alloc_d   = bad_alloc_q | (|(v_alloc_en & ~v_alloc_rdy));
        unique case (state_q)
            StNormal: begin
                free_bm_d     = (free_bm_q & ~alloc_mask) | release_mask;
                double_free_d = double_free_q | (|(release_mask & free_bm_q));
                if (v_flush_en) begin
                    state_d = StRecover;
                end
            end
            StRecover: begin
                // Commit is quiescent here; releases and repeated flushes are dropped.
                free_bm_d = ~arch_mask;
                state_d   = StNormal;
            end
            default: state_d = StNormal;
        endcase
        free_cnt_d = popcount(free_bm_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StNormal;
            free_bm_q     <= RESET_BM;
            free_cnt_q    <= FREE_CNT_WIDTH'(PHY_REG_NUM - ARCH_ENTRY_NUM);
            double_free_q <= 1'b0;
            bad_alloc_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            free_bm_q     <= free_bm_d;
            free_cnt_q    <= free_cnt_d;
            double_free_q <= double_free_d;
            bad_alloc_q   <= bad_alloc_d;
        end
    end

    assign v_free_cnt      = free_cnt_q;
    assign err_double_free = double_free_q;
    assign err_bad_alloc   = bad_alloc_q;

endmodule

// File: tb/tb_toy_phy_reg_freelist.sv
// Directed table plus randomized stimulus against a free-set reference model.
module tb_toy_phy_reg_freelist;
    import toy_pack::*;

    localparam int NP = 64;
    localparam int NA = 32;
    localparam int NL = 4;

    logic                      clk;
    logic                      rst_n;
    logic [NP-1:0]             rel, relc;
    logic [NA-1:0][5:0]        backup;
    logic                      flush;
    logic [NL-1:0]             rdy;
    logic [NL-1:0][5:0]        ids;
    logic [NL-1:0]             en;
    logic [6:0]                cnt;
    logic                      dbl, bad;

    int checks = 0;
    int failures = 0;

    toy_phy_reg_freelist #(
        .MODE     (0),
        .ALLOC_CH (NL)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .v_phy_release       (rel),
        .v_phy_release_comb  (relc),
        .v_reg_backup_phy_id (backup),
        .v_flush_en          (flush),
        .v_alloc_rdy         (rdy),
        .v_alloc_id          (ids),
        .v_alloc_en          (en),
        .v_free_cnt          (cnt),
        .err_double_free     (dbl),
        .err_bad_alloc       (bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: set of free IDs, a pending-rebuild flag and sticky errors.
    bit m_free[NP];
    bit m_recover;
    bit m_dbl, m_bad;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) m_free[i] = (i >= NA);
        m_recover = 0;
        m_dbl = 0;
        m_bad = 0;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NP; i++) c += int'(m_free[i]);
        return c;
    endfunction

    // Lane k offers the k-th smallest free ID while allocation is permitted.
    function automatic void model_lanes(input logic f, output logic [NL-1:0] x_rdy,
                                        output logic [NL-1:0][5:0] x_ids);
        int q[$];
        for (int i = 0; i < NP; i++) if (m_free[i]) q.push_back(i);
        x_rdy = '0;
        x_ids = '0;
        for (int k = 0; k < NL; k++) begin
            if (k < q.size() && !m_recover && !f) begin
                x_rdy[k] = 1'b1;
                x_ids[k] = 6'(q[k]);
            end
        end
    endfunction

    function automatic void model_update(input logic [NL-1:0] e, input logic [NP-1:0] r,
                                         input logic [NP-1:0] rc, input logic f,
                                         input logic [NL-1:0] x_rdy,
                                         input logic [NL-1:0][5:0] x_ids);
        bit nxt[NP];
        for (int k = 0; k < NL; k++) if (e[k] && !x_rdy[k]) m_bad = 1;
        if (m_recover) begin
            for (int i = 0; i < NP; i++) m_free[i] = 1;
            for (int j = 0; j < NA; j++) m_free[backup[j]] = 0;
            m_recover = 0;
        end else begin
            nxt = m_free;
            for (int k = 0; k < NL; k++) if (e[k] && x_rdy[k]) nxt[x_ids[k]] = 0;
            for (int i = 0; i < NP; i++) begin
                if (r[i] || rc[i]) begin
                    if (m_free[i]) m_dbl = 1;
                    nxt[i] = 1;
                end
            end
            m_free = nxt;
            if (f) m_recover = 1;
        end
    endfunction

    logic [NL-1:0]      x_rdy;
    logic [NL-1:0][5:0] x_ids;

    task automatic step(input logic [NL-1:0] e, input logic [NP-1:0] r,
                        input logic [NP-1:0] rc, input logic f);
        en = e;
        rel = r;
        relc = rc;
        flush = f;
        @(negedge clk);
        model_lanes(f, x_rdy, x_ids);
        check("rdy", 64'(rdy), 64'(x_rdy));
        check("ids", 64'(ids), 64'(x_ids));
        check("free_cnt", 64'(cnt), 64'(model_count()));
        check("errs", {62'd0, dbl, bad}, {62'd0, m_dbl, m_bad});
        @(posedge clk);
        model_update(e, r, rc, f, x_rdy, x_ids);
        #1;
    endtask

    typedef struct {
        logic [NL-1:0] en;
        int            rel;
        int            relc;
        logic          flush;
        bit            remap;
        logic [NL-1:0] x_rdy;
        int            x_id0;
        int            x_cnt;
        bit            x_bad;
        bit            x_dbl;
    } vec_t;

    vec_t tab[20];

    function automatic vec_t mk(logic [NL-1:0] e, int r, int rc, logic f, bit rm,
                                logic [NL-1:0] xr, int xi, int xc, bit xb, bit xd);
        vec_t v;
        v.en = e; v.rel = r; v.relc = rc; v.flush = f; v.remap = rm;
        v.x_rdy = xr; v.x_id0 = xi; v.x_cnt = xc; v.x_bad = xb; v.x_dbl = xd;
        return v;
    endfunction

    function automatic void set_identity();
        for (int j = 0; j < NA; j++) backup[j] = 6'(j);
    endfunction

    initial begin
        logic [NP-1:0] r, rc;
        logic          f;

        tab[0]  = mk(4'h5, -1, -1, 0, 0, 4'hF, 32, 32, 0, 0);
        tab[1]  = mk(4'h0, -1, -1, 0, 0, 4'hF, 33, 30, 0, 0);
        tab[2]  = mk(4'hF, -1, -1, 0, 0, 4'hF, 33, 30, 0, 0);
        tab[3]  = mk(4'hF, -1, -1, 0, 0, 4'hF, 38, 26, 0, 0);
        tab[4]  = mk(4'hF, -1, -1, 0, 0, 4'hF, 42, 22, 0, 0);
        tab[5]  = mk(4'hF, -1, -1, 0, 0, 4'hF, 46, 18, 0, 0);
        tab[6]  = mk(4'hF, -1, -1, 0, 0, 4'hF, 50, 14, 0, 0);
        tab[7]  = mk(4'hF, -1, -1, 0, 0, 4'hF, 54, 10, 0, 0);
        tab[8]  = mk(4'hF, -1, -1, 0, 0, 4'hF, 58, 6,  0, 0);
        tab[9]  = mk(4'h4, -1, -1, 0, 0, 4'h3, 62, 2,  0, 0);
        tab[10] = mk(4'h0,  5, 40, 0, 0, 4'h3, 62, 2,  1, 0);
        tab[11] = mk(4'h0,  5, -1, 0, 0, 4'hF, 5,  4,  1, 0);
        tab[12] = mk(4'h0, -1, -1, 0, 0, 4'hF, 5,  4,  1, 1);
        tab[13] = mk(4'hF, -1, -1, 0, 0, 4'hF, 5,  4,  1, 1);
        tab[14] = mk(4'h0, -1, -1, 1, 0, 4'h0, 0,  0,  1, 1);
        tab[15] = mk(4'h0, -1, -1, 0, 0, 4'h0, 0,  0,  1, 1);
        tab[16] = mk(4'h0, -1, -1, 0, 0, 4'hF, 32, 32, 1, 1);
        tab[17] = mk(4'h0, -1, -1, 1, 1, 4'h0, 0,  32, 1, 1);
        tab[18] = mk(4'h0, -1, -1, 0, 1, 4'h0, 0,  32, 1, 1);
        tab[19] = mk(4'h0, -1, -1, 0, 1, 4'hF, 3,  32, 1, 1);

        rst_n = 1'b0;
        en = '0; rel = '0; relc = '0; flush = 1'b0;
        set_identity();
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 20; t++) begin
            r = '0;
            rc = '0;
            if (tab[t].rel >= 0) r[tab[t].rel] = 1'b1;
            if (tab[t].relc >= 0) rc[tab[t].relc] = 1'b1;
            set_identity();
            if (tab[t].remap) backup[3] = 6'd50;
            en = tab[t].en; rel = r; relc = rc; flush = tab[t].flush;
            @(negedge clk);
            check($sformatf("tab%0d_rdy", t), 64'(rdy), 64'(tab[t].x_rdy));
            check($sformatf("tab%0d_id0", t), 64'(ids[0]), 64'(tab[t].x_id0));
            check($sformatf("tab%0d_cnt", t), 64'(cnt), 64'(tab[t].x_cnt));
            check($sformatf("tab%0d_err", t), {62'd0, dbl, bad},
                  {62'd0, tab[t].x_dbl, tab[t].x_bad});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while a rebuild is pending must leave no RECOVER behind.
        set_identity();
        en = '0; rel = '0; relc = '0; flush = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        flush = 1'b0;
        #1;
        check("async_rst_cnt", 64'(cnt), 64'd32);
        check("async_rst_err", {62'd0, dbl, bad}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'h0, '0, '0, 1'b0);
        step(4'hA, '0, '0, 1'b0);

        for (int c = 0; c < 400; c++) begin
            r = '0;
            rc = '0;
            for (int i = 0; i < NP; i++) begin
                if (!m_free[i] && $urandom_range(0, 19) == 0) r[i] = 1'b1;
                if (!m_free[i] && $urandom_range(0, 39) == 0) rc[i] = 1'b1;
                if (m_free[i] && $urandom_range(0, 499) == 0) r[i] = 1'b1;
            end
            f = ($urandom_range(0, 11) == 0);
            if (f) begin
                set_identity();
                for (int s = 0; s < 4; s++) backup[$urandom_range(0, NA - 1)] = 6'($urandom_range(0, NP - 1));
            end
            step(4'($urandom), r, rc, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toy_phy_reg_freelist.md
# toy_phy_reg_freelist

Physical register free list for the rename stage. It sits directly downstream of the backup (architectural) rename regfile and consumes that block's per-cycle release vectors. It presents up to ALLOC_CH free physical IDs per cycle to rename. On a pipeline flush it rebuilds the free map from the committed architectural mapping. One instance is used per register class, INT or FP.

## Interface
Parameters:
- MODE, 0, register class: 0 = INT, 1 = FP. Affects only reset state, see Operation.
- ALLOC_CH, 4, number of allocation lanes per cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- v_phy_release  in  PHY_REG_NUM  one-hot-per-reg release pulses: old mappings displaced at commit.
- v_phy_release_comb  in  PHY_REG_NUM  release pulses for IDs allocated and overwritten inside the same commit group.
- v_reg_backup_phy_id  in  PHY_REG_ID_WIDTH x ARCH_ENTRY_NUM  committed arch→phy mapping.
- v_flush_en  in  1  pipeline flush pulse.
- v_alloc_rdy  out  ALLOC_CH  lane k holds a valid free ID.
- v_alloc_id  out  PHY_REG_ID_WIDTH x ALLOC_CH  lane k free ID.
- v_alloc_en  in  ALLOC_CH  rename consumes lane k this cycle.
- v_free_cnt  out  $clog2(PHY_REG_NUM+1)  registered count of free registers.
- err_double_free  out  1  sticky: a released ID was already free.
- err_bad_alloc  out  1  sticky: v_alloc_en[k] was asserted while v_alloc_rdy[k]=0.

## Operation
- State: free_bm[PHY_REG_NUM] (1 = free), free_cnt, 2-state FSM {NORMAL, RECOVER}.
- Reset values:
  - free_bm: bits 0..ARCH_ENTRY_NUM-1 = 0, which matches the identity backup mapping; all others = 1.
  - free_cnt = PHY_REG_NUM-ARCH_ENTRY_NUM.
  - FSM = NORMAL.
  - Both error flags = 0.
- Lane pick:
  - v_alloc_id[k] is the (k+1)-th lowest set bit of free_bm. It is combinational from registers.
  - v_alloc_rdy[k] = (free_cnt > k) && FSM==NORMAL && !v_flush_en.
  - When a lane is not ready, v_alloc_id[k] = 0.
- Allocation:
  - Any subset of ready lanes may be consumed.
  - alloc_mask = OR over k of onehot(v_alloc_id[k]) & v_alloc_en[k] & v_alloc_rdy[k].
  - Lanes that are not consumed stay free.
- NORMAL update:
  - free_bm <= (free_bm & ~alloc_mask) | v_phy_release | v_phy_release_comb.
  - free_cnt <= popcount of the next value of free_bm.
- Duplicate IDs are legal. The same ID may be present in both release vectors, or in several channels; the OR semantics free it once.
- err_double_free sets if (v_phy_release | v_phy_release_comb) & free_bm is nonzero. That bitmap update still applies.
- Flush:
  - When v_flush_en=1 in NORMAL, releases in that cycle are applied, allocation is blocked, and FSM → RECOVER.
  - In RECOVER: free_bm <= ~arch_mask, where arch_mask = OR over j of onehot(v_reg_backup_phy_id[j]). free_cnt <= PHY_REG_NUM - popcount(arch_mask). FSM → NORMAL.
  - Release inputs in RECOVER are ignored. Commit is quiescent after a flush.
  - v_flush_en in RECOVER is ignored. The FSM stays one cycle in RECOVER, then returns to NORMAL.
- MODE has no effect beyond the reset state. Both classes reset identically.

## Timing
- An ID released in cycle T appears on v_alloc_id in cycle T+1 at the earliest.
- An ID allocated in T is absent from the lanes in T+1.
- Flush asserted in T:
  - v_alloc_rdy = 0 in T and T+1.
  - The rebuilt map is visible in T+2.
  - T+1 sees the backup mapping that includes the commits from T.
- v_free_cnt always equals popcount(free_bm). It is updated in the same edge as free_bm.
- Asynchronous reset mid-flush returns the block to the reset state. No RECOVER is pending after reset.

## Structure
- Add to toy_pack: RENAME_ALLOC_CHANNEL (=4). Reuse the existing PHY_REG_NUM, PHY_REG_ID_WIDTH and ARCH_ENTRY_NUM.
- Sub-module toy_phy_freelist_pick: parameterised find-N-lowest-set-bits over PHY_REG_NUM. Outputs per-lane valid, ID and one-hot. Purely combinational.
- The top level holds the bitmap, counter, FSM, arch_mask reduction and error flags.

## Test plan
All scenarios use PHY_REG_NUM=64, ARCH_ENTRY_NUM=32, ALLOC_CH=4.
- Reset → v_alloc_id = {32,33,34,35}, v_alloc_rdy=4'hF, v_free_cnt=32, both errors 0.
- v_alloc_en=4'b0101 → next cycle lanes = {33,35,36,37}, v_free_cnt=30.
- Allocate until 2 registers are free → v_alloc_rdy=4'b0011. Asserting v_alloc_en[2] sets err_bad_alloc and leaves the bitmap unchanged.
- Pulse v_phy_release bit 5 and v_phy_release_comb bit 40, with 40 already allocated and 5 allocated → next cycle both are free, v_free_cnt +2, lane0=5. A repeat release of 5 sets err_double_free.
- Allocate 10 IDs, then v_flush_en=1 with the backup mapping at identity → rdy low for 2 cycles. In the 3rd cycle free_bm restores bits 32..63, v_free_cnt=32.
- Flush with backup entry 3 remapped to 50 → after recovery phy 3 is free, phy 50 is not, lane0=3.
